// File: rtl/pm_pkt_arbiter_pkg.sv
// Shared types and constants for the pattern-matcher packet arbiter.
// Also holds the modulo pointer helper that the arbiters reuse.
package pm_pkt_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PKT       = 2'd1,
      ST_WAIT_META = 2'd2
   } arb_state_e;

   localparam logic [7:0] REG_PMARB_PKT  = 8'h00;
   localparam logic [7:0] REG_PMARB_META = 8'h04;
   localparam logic [7:0] REG_PMARB_ERR  = 8'h08;

   // Explicit wrap so non-power-of-2 channel counts rotate correctly.
   function automatic int unsigned rr_wrap_inc(input int unsigned p, input int unsigned n);
      return (p + 1 >= n) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/pm_pkt_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req searching
// ptr, ptr+1, ... modulo N.
module pm_pkt_arbiter_rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int unsigned IW = $clog2(N);

   int unsigned cand;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N) cand = cand - N;
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/pm_pkt_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN matcher result channels into one
// packet stream plus one meta stream, with exactly one meta word per packet.
module pm_pkt_arbiter
   import pm_pkt_arbiter_pkg::*;
#(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned DWIDTH = 512,
   parameter int unsigned EWIDTH = 6,
   parameter int unsigned MWIDTH = 128
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [NUM_IN*DWIDTH-1:0]   in_pkt_data,
   input  logic [NUM_IN-1:0]          in_pkt_valid,
   input  logic [NUM_IN-1:0]          in_pkt_sop,
   input  logic [NUM_IN-1:0]          in_pkt_eop,
   input  logic [NUM_IN*EWIDTH-1:0]   in_pkt_empty,
   output logic [NUM_IN-1:0]          in_pkt_ready,
   input  logic [NUM_IN*MWIDTH-1:0]   in_meta_data,
   input  logic [NUM_IN-1:0]          in_meta_valid,
   output logic [NUM_IN-1:0]          in_meta_ready,
   output logic [DWIDTH-1:0]          out_pkt_data,
   output logic                       out_pkt_valid,
   output logic                       out_pkt_sop,
   output logic                       out_pkt_eop,
   output logic [EWIDTH-1:0]          out_pkt_empty,
   input  logic                       out_pkt_ready,
   output logic [MWIDTH-1:0]          out_meta_data,
   output logic                       out_meta_valid,
   input  logic                       out_meta_ready,
   output logic [31:0]                stats_pkt,
   output logic [31:0]                stats_meta,
   output logic [31:0]                stats_err,
   output logic [$clog2(NUM_IN)-1:0]  cur_sel
);

   localparam int unsigned SW = $clog2(NUM_IN);

   arb_state_e     state_q, state_d;
   logic [SW-1:0]  sel_q, sel_d;
   logic [SW-1:0]  rr_q, rr_d;
   logic           meta_sent_q, meta_sent_d;
   logic [31:0]    pkt_cnt_q, pkt_cnt_d;
   logic [31:0]    meta_cnt_q, meta_cnt_d;
   logic [31:0]    err_cnt_q, err_cnt_d;

   logic [NUM_IN-1:0] elig;
   logic [NUM_IN-1:0] orphan;
   logic [31:0]       orphan_cnt;
   logic [SW-1:0]     pick_idx;
   logic              pick_found;
   logic              meta_hs;

   assign elig = in_pkt_valid & in_pkt_sop & in_meta_valid;

   pm_pkt_arbiter_rr_pick #(.N(NUM_IN)) u_rr_pick (
      .req   (elig),
      .ptr   (rr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign out_pkt_data  = in_pkt_data[sel_q*DWIDTH +: DWIDTH];
   assign out_pkt_sop   = in_pkt_sop[sel_q];
   assign out_pkt_eop   = in_pkt_eop[sel_q];
   assign out_pkt_empty = in_pkt_empty[sel_q*EWIDTH +: EWIDTH];
   assign out_meta_data = in_meta_data[sel_q*MWIDTH +: MWIDTH];

   assign stats_pkt  = pkt_cnt_q;
   assign stats_meta = meta_cnt_q;
   assign stats_err  = err_cnt_q;
   assign cur_sel    = sel_q;

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      rr_d           = rr_q;
      meta_sent_d    = meta_sent_q;
      pkt_cnt_d      = pkt_cnt_q;
      meta_cnt_d     = meta_cnt_q;
      err_cnt_d      = err_cnt_q;
      in_pkt_ready   = '0;
      in_meta_ready  = '0;
      out_pkt_valid  = 1'b0;
      out_meta_valid = 1'b0;
      orphan         = '0;
      orphan_cnt     = '0;

      // Meta path is shared by PKT and WAIT_META; one word per granted packet.
      if (state_q != ST_IDLE) begin
         out_meta_valid       = in_meta_valid[sel_q] && !meta_sent_q;
         in_meta_ready[sel_q] = out_meta_ready && !meta_sent_q;
      end
      meta_hs = out_meta_valid && out_meta_ready;
      if (meta_hs) begin
         meta_sent_d = 1'b1;
         meta_cnt_d  = meta_cnt_q + 32'd1;
      end

      case (state_q)
         ST_IDLE: begin
            // Gated by reset so readies read zero while reset is held.
            orphan       = in_pkt_valid & ~in_pkt_sop & {NUM_IN{Rst_n}};
            in_pkt_ready = orphan;
            for (int unsigned i = 0; i < NUM_IN; i++)
               orphan_cnt = orphan_cnt + 32'(orphan[i]);
            err_cnt_d = err_cnt_q + orphan_cnt;
            if (pick_found) begin
               sel_d       = pick_idx;
               meta_sent_d = 1'b0;
               state_d     = ST_PKT;
            end
         end
         ST_PKT: begin
            out_pkt_valid       = in_pkt_valid[sel_q];
            in_pkt_ready[sel_q] = out_pkt_ready;
            if (out_pkt_valid && out_pkt_ready && in_pkt_eop[sel_q]) begin
               pkt_cnt_d = pkt_cnt_q + 32'd1;
               if (meta_sent_q || meta_hs) begin
                  state_d = ST_IDLE;
                  rr_d    = SW'(rr_wrap_inc(32'(sel_q), NUM_IN));
               end else begin
                  state_d = ST_WAIT_META;
               end
            end
         end
         ST_WAIT_META: begin
            if (meta_hs) begin
               state_d = ST_IDLE;
               rr_d    = SW'(rr_wrap_inc(32'(sel_q), NUM_IN));
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         rr_q        <= '0;
         meta_sent_q <= 1'b0;
         pkt_cnt_q   <= '0;
         meta_cnt_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         rr_q        <= rr_d;
         meta_sent_q <= meta_sent_d;
         pkt_cnt_q   <= pkt_cnt_d;
         meta_cnt_q  <= meta_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

endmodule
